// File: rtl/fir_tdm_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_tdm_filter                                               |
// | Description : Multichannel FIR, one time-shared MAC, N_TAPS cycles/sample, |
// |               per-channel circular history, double-banked coefficients.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_tdm_filter #(
    parameter int N_TAPS    = 64,
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15,
    parameter int CHANNELS  = 2,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int TAP_W    = $clog2(N_TAPS),
    localparam int ACC_W    = DATA_W + COEF_W + TAP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [CH_W-1:0]   in_chan,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [CH_W-1:0]   out_chan,
    input  logic                     coef_we,
    input  logic        [TAP_W-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     coef_commit,
    output logic                     busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic        [TAP_W-1:0] c_LAST_K   = TAP_W'(N_TAPS - 1);
    localparam logic        [TAP_W:0]   c_N_TAPS   = (TAP_W + 1)'(N_TAPS);
    localparam logic        [CH_W:0]    c_CHANNELS = (CH_W + 1)'(CHANNELS);
    localparam logic signed [ACC_W:0]   c_HALF     = (ACC_W + 1)'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W:0]   c_SAT_MAX  = {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0]   c_SAT_MIN  = {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic        [1:0]        r_state;
    logic        [TAP_W-1:0]  r_k;
    logic        [CH_W-1:0]   r_ch;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [TAP_W-1:0]  r_wp   [CHANNELS];
    logic signed [DATA_W-1:0] r_hist [CHANNELS][N_TAPS];
    logic signed [COEF_W-1:0] r_coef [2][N_TAPS];
    logic                     r_active;
    logic                     r_pending;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic        [CH_W-1:0]   r_out_chan;

    logic                     w_accept;
    logic                     w_chan_ok;
    logic                     w_swap;
    logic        [TAP_W-1:0]  w_wp_cur;
    logic        [TAP_W:0]    w_wrap;
    logic        [TAP_W-1:0]  w_tap_idx;
    logic signed [DATA_W-1:0] w_hist_rd;
    logic signed [COEF_W-1:0] w_coef_rd;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_shift;
    logic signed [DATA_W-1:0] w_sat;

    assign in_ready  = rst_n && enable && (r_state == S_IDLE);
    assign busy      = (r_state == S_MAC) || (r_state == S_OUT);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

    assign w_accept  = in_valid && in_ready;
    assign w_chan_ok = ({1'b0, in_chan} < c_CHANNELS);
    // Banks only flip between samples, so a running MAC never sees a mixed set.
    assign w_swap    = (r_state == S_IDLE) && (r_pending || coef_commit);

    // Tap k reads the sample written k accepts ago on this channel.
    always_comb begin
        w_wp_cur  = r_wp[r_ch];
        w_wrap    = {1'b0, w_wp_cur} + c_N_TAPS - {1'b0, r_k};
        if (w_wp_cur >= r_k) begin
            w_tap_idx = w_wp_cur - r_k;
        end else begin
            w_tap_idx = w_wrap[TAP_W-1:0];
        end
        w_hist_rd = r_hist[r_ch][w_tap_idx];
        w_coef_rd = r_coef[r_active][r_k];
    end

    assign w_prod  = PROD_W'(w_hist_rd) * PROD_W'(w_coef_rd);
    assign w_sum   = (ACC_W + 1)'(r_acc) + c_HALF;
    assign w_shift = w_sum >>> COEF_FRAC;

    always_comb begin
        if (w_shift > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[DATA_W-1:0];
        end else if (w_shift < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[DATA_W-1:0];
        end else begin
            w_sat = w_shift[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            r_active    <= 1'b0;
            r_pending   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_wp[c] <= '0;
                for (int t = 0; t < N_TAPS; t++) begin
                    r_hist[c][t] <= '0;
                end
            end
        end else begin
            r_out_valid <= 1'b0;

            if (w_swap) begin
                r_active  <= ~r_active;
                r_pending <= 1'b0;
            end else if (coef_commit) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // Out-of-range channels are consumed by the handshake and dropped.
                    if (w_accept && w_chan_ok) begin
                        r_hist[in_chan][r_wp[in_chan]] <= in_data;
                        r_ch    <= in_chan;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_k == c_LAST_K) begin
                        r_wp[r_ch] <= (r_wp[r_ch] == c_LAST_K) ? '0 : r_wp[r_ch] + TAP_W'(1);
                        r_state    <= S_OUT;
                    end else begin
                        r_k <= r_k + TAP_W'(1);
                    end
                end
                S_OUT: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_sat;
                    r_out_chan  <= r_ch;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Coefficient storage is plain RAM; writes always target the shadow bank.
    always_ff @(posedge clk) begin
        if (coef_we && ({1'b0, coef_addr} < c_N_TAPS)) begin
            r_coef[~r_active][coef_addr] <= coef_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_tdm_filter                                            |
// | Description : Scoreboard bench for fir_tdm_filter with a convolution model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_tdm_filter;

    localparam int N_TAPS    = 12;
    localparam int DATA_W    = 24;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 15;
    localparam int CHANNELS  = 3;
    localparam int CH_W      = 2;
    localparam int TAP_W     = 4;

    localparam longint c_DMASK = (longint'(1) << DATA_W) - 1;
    localparam longint c_MAXV  = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint c_MINV  = -(longint'(1) << (DATA_W - 1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CH_W-1:0]   in_chan = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_chan;
    logic              coef_we = 1'b0;
    logic [TAP_W-1:0]  coef_addr = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              coef_commit = 1'b0;
    logic              busy;

    fir_tdm_filter #(
        .N_TAPS    (N_TAPS),
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .CHANNELS  (CHANNELS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_chan     (in_chan),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_hist[ch][j] is the j-th most recent sample of channel ch.
    longint m_coef [2][N_TAPS];
    longint m_hist [CHANNELS][N_TAPS];
    bit     m_active = 1'b0;

    typedef struct {
        longint data;
        int     chan;
        longint due;
    } exp_t;

    exp_t sb[$];

    function automatic longint sx(longint v, int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint model_step(int ch, longint x);
        longint acc;
        longint r;
        acc = 0;
        for (int t = N_TAPS - 1; t > 0; t--) m_hist[ch][t] = m_hist[ch][t-1];
        m_hist[ch][0] = x;
        for (int t = 0; t < N_TAPS; t++) acc += m_hist[ch][t] * m_coef[m_active][t];
        r = (acc + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
        if (r > c_MAXV) r = c_MAXV;
        if (r < c_MINV) r = c_MINV;
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++)
            for (int t = 0; t < N_TAPS; t++) m_hist[c][t] = 0;
        m_active = 1'b0;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(out_data), e.data & c_DMASK);
                check("out_chan", 64'(out_chan), 64'(e.chan));
                check("latency_edge", cyc, e.due);
            end
        end
    end

    task automatic send(int ch, longint x, int hold_off);
        int     waited;
        longint acc_edge;
        exp_t   e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x[DATA_W-1:0];
        in_chan  = ch[CH_W-1:0];
        if (hold_off > 0) begin
            enable = 1'b0;
            repeat (hold_off) begin
                #1 check("in_ready_while_disabled", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
        end
        enable = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            acc_edge = cyc + 1;
            @(posedge clk);
            if (ch < CHANNELS) begin
                e.data = model_step(ch, sx(x, DATA_W));
                e.chan = ch;
                e.due  = acc_edge + N_TAPS + 1;
                sb.push_back(e);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic write_coef(int k, longint v, bit commit);
        @(negedge clk);
        coef_we     = 1'b1;
        coef_addr   = k[TAP_W-1:0];
        coef_wdata  = v[COEF_W-1:0];
        coef_commit = commit;
        @(posedge clk);
        m_coef[!m_active][k] = sx(v, COEF_W);
        if (commit) m_active = !m_active;
        #1;
        coef_we     = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic commit_only();
        @(negedge clk);
        coef_commit = 1'b1;
        @(posedge clk);
        m_active = !m_active;
        #1 coef_commit = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic load_bank(input longint h[N_TAPS]);
        for (int t = 0; t < N_TAPS; t++) write_coef(t, h[t], t == N_TAPS - 1);
        wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint h [N_TAPS];
        longint z [N_TAPS];
        int     drain;
        int     rch;
        for (int t = 0; t < N_TAPS; t++) z[t] = 0;
        model_reset();

        enable   = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Defined contents in both banks before any sample flows.
        load_bank(z);
        load_bank(z);

        // Impulse through h[0] = 0.5.
        h = z; h[0] = 'h4000;
        load_bank(h);
        send(0, 'h100000, 0);
        wait_idle();

        // Reset in the middle of MAC: no output, bank 0 active, histories cleared.
        send(0, 'h123456, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        model_reset();
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_out_valid", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        send(0, 'h040000, 0);
        wait_idle();
        h = z; h[0] = 'h4000; h[1] = 'h4000; h[2] = 'h4000; h[3] = 'h4000;
        load_bank(h);
        send(0, 'h020000, 0);
        wait_idle();

        // Channel isolation through h[3].
        h = z; h[3] = 'h7FFF;
        load_bank(h);
        load_bank(z);
        load_bank(h);
        send(0, 'h010000, 0);
        send(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send(0, 0, 0);
            send(1, 0, 0);
        end

        // Saturation and rounding at both rails.
        h = z; h[0] = 'h7FFF; h[1] = 'h7FFF;
        load_bank(h);
        send(2, 'h7FFFFF, 0);
        send(2, 'h7FFFFF, 0);
        send(1, 'h800000, 0);
        send(1, 'h800000, 0);
        wait_idle();

        // Glitch-free bank swap: commit while a sample is in MAC.
        load_bank(z);
        h = z; h[0] = 'h4000;
        load_bank(h);
        send(2, 'h200000, 0);
        #1 check("busy_in_mac", 64'(busy), 64'd1);
        write_coef(0, 'h2000, 1'b0);
        commit_only();
        send(2, 0, 0);
        send(2, 'h200000, 0);
        wait_idle();

        // Enable gating, out-of-range channel.
        send(0, 'h0ABCDE, 4);
        send(3, 'h7ABCDE, 2);
        #1 check("oor_stays_idle", 64'(busy), 64'd0);
        send(0, 'h011111, 1);
        send(1, 'h022222, 0);
        send(2, 'h033333, 0);

        // Randomized traffic with occasional coefficient updates.
        for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int t = 0; t < N_TAPS; t++)
                    h[t] = sx(longint'($urandom_range(0, 65535)), COEF_W) >>> $urandom_range(0, 4);
                wait_idle();
                load_bank(h);
            end
            rch = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, CHANNELS - 1));
            send(rch, sx(longint'($urandom), DATA_W), int'($urandom_range(0, 2)));
            if (rch < CHANNELS && $urandom_range(0, 3) == 0) begin
                write_coef(int'($urandom_range(0, N_TAPS - 1)),
                           sx(longint'($urandom), COEF_W), bit'($urandom_range(0, 1)));
                wait_idle();
            end
        end

        drain = 0;
        while (sb.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
